// File: rtl/apb_uart_arbiter.sv
// apb_uart_arbiter: round-robin arbiter that serialises N_REQ APB requesters
// onto a single APB completer (mock UART). Each granted transfer is replayed
// on the completer side as an explicit SETUP/ACCESS sequence, and IDLE is
// always visited between transfers.
// Optional feature: define APB_UART_ARB_WATCHDOG_EN to abort ACCESS phases
// that see no completer response for TIMEOUT cycles (answered with pslverr).

// Protocol checker: a requester that has been selected but not yet served
// must keep psel (and, once in its access phase, penable) asserted.
module apb_uart_arbiter_chk #(
    parameter int N_REQ = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] psel,
    input  logic [N_REQ-1:0] penable,
    input  logic [N_REQ-1:0] pready
);
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        a_psel_held: assert property (@(posedge clk_i) disable iff (rst_i)
            (psel[i] && !pready[i]) |=> psel[i]);
        a_penable_held: assert property (@(posedge clk_i) disable iff (rst_i)
            (psel[i] && penable[i] && !pready[i]) |=> penable[i]);
    end
endmodule

module apb_uart_arbiter #(
    parameter int N_REQ      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_psel_i,
    input  logic [N_REQ-1:0]              req_penable_i,
    input  logic [N_REQ-1:0]              req_pwrite_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_paddr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_pwdata_i,
    output logic [N_REQ-1:0]              req_pready_o,
    output logic [N_REQ*DATA_WIDTH-1:0]   req_prdata_o,
    output logic [N_REQ-1:0]              req_pslverr_o,
    output logic                          cpl_psel_o,
    output logic                          cpl_penable_o,
    output logic                          cpl_pwrite_o,
    output logic [ADDR_WIDTH-1:0]         cpl_paddr_o,
    output logic [DATA_WIDTH-1:0]         cpl_pwdata_o,
    input  logic                          cpl_pready_i,
    input  logic                          cpl_pslverr_i,
    input  logic [DATA_WIDTH-1:0]         cpl_prdata_i,
    output logic [$clog2(N_REQ)-1:0]      grant_idx_o
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Elaboration-time sanity check of the configuration
    if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_uart_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic [IDX_W-1:0]      win_idx_s;
    logic [IDX_W-1:0]      cand_s;
    int                    cand_v;
    logic                  found_s;
    logic                  done_s;
    logic                  timeout_s;

    assign found_s = |req_psel_i;

    // Round-robin search; scanning from the far end down to rr_ptr_r lets the
    // last hit (closest to rr_ptr_r) win without an early exit.
    always_comb begin
        win_idx_s = rr_ptr_r;
        cand_v    = 0;
        cand_s    = {IDX_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_v    = (int'(rr_ptr_r) + k) % N_REQ;
            cand_s    = IDX_W'(cand_v);
            win_idx_s = req_psel_i[cand_s] ? cand_s : win_idx_s;
        end
    end

`ifdef APB_UART_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_r;

    // A completer that stays silent for TIMEOUT ACCESS cycles is abandoned;
    // a real response arriving in that same cycle still takes precedence.
    assign timeout_s = (state_r == ST_ACCESS) && !cpl_pready_i &&
                       (wd_cnt_r == WD_W'(TIMEOUT));

    // Count stalled ACCESS cycles; cleared whenever ACCESS is left
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_ACCESS) && !cpl_pready_i && !timeout_s) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= {WD_W{1'b0}};
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    assign done_s = (state_r == ST_ACCESS) && (cpl_pready_i || timeout_s);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: no preemption once SETUP has started
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = found_s ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: state_nxt_s = done_s ? ST_IDLE : ST_ACCESS;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Capture the winner in IDLE and advance the pointer past the owner on completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r <= {IDX_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            pwrite_r <= 1'b0;
            paddr_r  <= {ADDR_WIDTH{1'b0}};
            pwdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && found_s) begin
                idx_r    <= win_idx_s;
                pwrite_r <= req_pwrite_i[win_idx_s];
                paddr_r  <= req_paddr_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                pwdata_r <= req_pwdata_i[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
            end
            if (done_s) begin
                rr_ptr_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + 1'b1;
            end
        end
    end

    // FSM outputs: completer handshake and the owner's completion response
    always_comb begin
        cpl_psel_o    = 1'b0;
        cpl_penable_o = 1'b0;
        cpl_pwrite_o  = 1'b0;
        req_pready_o  = {N_REQ{1'b0}};
        req_prdata_o  = {(N_REQ*DATA_WIDTH){1'b0}};
        req_pslverr_o = {N_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                cpl_psel_o = 1'b0;
            end
            ST_SETUP: begin
                cpl_psel_o   = 1'b1;
                cpl_pwrite_o = pwrite_r;
            end
            ST_ACCESS: begin
                cpl_psel_o    = 1'b1;
                cpl_penable_o = 1'b1;
                cpl_pwrite_o  = pwrite_r;
                if (done_s) begin
                    req_pready_o[idx_r] = 1'b1;
                    if (timeout_s) begin
                        req_pslverr_o[idx_r] = 1'b1;
                    end else begin
                        req_pslverr_o[idx_r]                           = cpl_pslverr_i;
                        req_prdata_o[idx_r*DATA_WIDTH +: DATA_WIDTH]   = cpl_prdata_i;
                    end
                end else begin
                    req_pready_o = {N_REQ{1'b0}};
                end
            end
            default: begin
                cpl_psel_o = 1'b0;
            end
        endcase
    end

    assign cpl_paddr_o  = paddr_r;
    assign cpl_pwdata_o = pwdata_r;
    assign grant_idx_o  = idx_r;

    apb_uart_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .psel    (req_psel_i),
        .penable (req_penable_i),
        .pready  (req_pready_o)
    );

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed testbench for apb_uart_arbiter (N_REQ=8, 32-bit address/data).
// A small behavioural completer with programmable wait states sits on the
// completer port; expected values are hand-derived per cycle.
module tb_apb_uart_arbiter;
    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 3;

    logic            clk_s = 1'b0;
    logic            rst_s;
    logic [N-1:0]    req_psel_s;
    logic [N-1:0]    req_penable_s;
    logic [N-1:0]    req_pwrite_s;
    logic [N*AW-1:0] req_paddr_s;
    logic [N*DW-1:0] req_pwdata_s;
    logic [N-1:0]    req_pready_s;
    logic [N*DW-1:0] req_prdata_s;
    logic [N-1:0]    req_pslverr_s;
    logic            cpl_psel_s;
    logic            cpl_penable_s;
    logic            cpl_pwrite_s;
    logic [AW-1:0]   cpl_paddr_s;
    logic [DW-1:0]   cpl_pwdata_s;
    logic            cpl_pready_s;
    logic            cpl_pslverr_s;
    logic [DW-1:0]   cpl_prdata_s;
    logic [IW-1:0]   grant_idx_s;

    int            wait_cfg;
    logic [DW-1:0] rdata_cfg;
    logic          err_cfg;
    int            wcnt_r;
    int            pready_cnt[N];
    int            seen_cnt[N];
    int            order_q[$];
    logic [DW-1:0] wdata_q[$];
    int            n_cmp;
    int            n_err;

    apb_uart_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
    ) dut (
        .clk_i         (clk_s),
        .rst_i         (rst_s),
        .req_psel_i    (req_psel_s),
        .req_penable_i (req_penable_s),
        .req_pwrite_i  (req_pwrite_s),
        .req_paddr_i   (req_paddr_s),
        .req_pwdata_i  (req_pwdata_s),
        .req_pready_o  (req_pready_s),
        .req_prdata_o  (req_prdata_s),
        .req_pslverr_o (req_pslverr_s),
        .cpl_psel_o    (cpl_psel_s),
        .cpl_penable_o (cpl_penable_s),
        .cpl_pwrite_o  (cpl_pwrite_s),
        .cpl_paddr_o   (cpl_paddr_s),
        .cpl_pwdata_o  (cpl_pwdata_s),
        .cpl_pready_i  (cpl_pready_s),
        .cpl_pslverr_i (cpl_pslverr_s),
        .cpl_prdata_i  (cpl_prdata_s),
        .grant_idx_o   (grant_idx_s)
    );

    // Clock
    always #5 clk_s = ~clk_s;

    // Mock completer: ready after wait_cfg stalled ACCESS cycles
    assign cpl_pready_s  = cpl_psel_s & cpl_penable_s & (wcnt_r == wait_cfg);
    assign cpl_prdata_s  = rdata_cfg;
    assign cpl_pslverr_s = err_cfg;

    // Completer wait-state counter
    always @(posedge clk_s) begin
        if (cpl_psel_s && cpl_penable_s && !cpl_pready_s) wcnt_r <= wcnt_r + 1;
        else wcnt_r <= 0;
    end

    // Record per-requester completions, service order and completer writes
    always @(negedge clk_s) begin
        if (!rst_s) begin
            for (int i = 0; i < N; i++) begin
                if (req_pready_s[i]) begin
                    pready_cnt[i] <= pready_cnt[i] + 1;
                    order_q.push_back(i);
                end
            end
            if (cpl_psel_s && cpl_penable_s && cpl_pready_s) wdata_q.push_back(cpl_pwdata_s);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: requesters that were served drop psel, the rest enter/keep access
    task automatic cyc();
        logic [N-1:0] prev;
        @(posedge clk_s);
        #1;
        prev = req_psel_s;
        for (int i = 0; i < N; i++) begin
            if (pready_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i]   = pready_cnt[i];
                req_psel_s[i] = 1'b0;
            end
        end
        req_penable_s = prev & req_psel_s;
        @(negedge clk_s);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_pwrite_s[i]          = w;
        req_paddr_s[i*AW +: AW]  = a;
        req_pwdata_s[i*DW +: DW] = d;
        req_psel_s[i]            = 1'b1;
    endtask

    task automatic do_reset();
        rst_s         = 1'b1;
        req_psel_s    = '0;
        req_penable_s = '0;
        repeat (2) @(negedge clk_s);
        rst_s = 1'b0;
        #1;
    endtask

    task automatic run_idle(input int budget, input string tag);
        for (int c = 0; c < budget && req_psel_s != '0; c++) cyc();
        chk(tag, 256'(req_psel_s), 256'(8'h00));
    endtask

    function automatic int q_at(input int pos);
        return (pos < order_q.size()) ? order_q[pos] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1, "time limit exceeded");
    end

    initial begin
        int            base;
        int            wbase;
        int            cnt0[N];
        logic [255:0]  exp_rd;
        n_cmp        = 0;
        n_err        = 0;
        wait_cfg     = 0;
        rdata_cfg    = 32'h0;
        err_cfg      = 1'b0;
        req_pwrite_s = '0;
        req_paddr_s  = '0;
        req_pwdata_s = '0;
        do_reset();

        // Reset state
        chk("rst_cpl_psel",    256'(cpl_psel_s),    256'(1'b0));
        chk("rst_cpl_penable", 256'(cpl_penable_s), 256'(1'b0));
        chk("rst_cpl_pwrite",  256'(cpl_pwrite_s),  256'(1'b0));
        chk("rst_cpl_paddr",   256'(cpl_paddr_s),   256'(32'h0));
        chk("rst_cpl_pwdata",  256'(cpl_pwdata_s),  256'(32'h0));
        chk("rst_req_pready",  256'(req_pready_s),  256'(8'h00));
        chk("rst_req_prdata",  256'(req_prdata_s),  256'(1'b0));
        chk("rst_req_pslverr", 256'(req_pslverr_s), 256'(8'h00));
        chk("rst_grant_idx",   256'(grant_idx_s),   256'(3'd0));

        // Requester 3 writes 0x41 to 0x08, zero-wait completer
        set_req(3, 1'b1, 32'h08, 32'h41);
        cyc();
        chk("t1_setup_psel",    256'(cpl_psel_s),    256'(1'b1));
        chk("t1_setup_penable", 256'(cpl_penable_s), 256'(1'b0));
        chk("t1_setup_paddr",   256'(cpl_paddr_s),   256'(32'h08));
        chk("t1_setup_pwdata",  256'(cpl_pwdata_s),  256'(32'h41));
        chk("t1_setup_pwrite",  256'(cpl_pwrite_s),  256'(1'b1));
        chk("t1_setup_pready",  256'(req_pready_s),  256'(8'h00));
        chk("t1_setup_grant",   256'(grant_idx_s),   256'(3'd3));
        cyc();
        chk("t1_access_psel",    256'(cpl_psel_s),    256'(1'b1));
        chk("t1_access_penable", 256'(cpl_penable_s), 256'(1'b1));
        chk("t1_access_pready",  256'(req_pready_s),  256'(8'h08));
        cyc();
        chk("t1_idle_psel",   256'(cpl_psel_s),   256'(1'b0));
        chk("t1_idle_pready", 256'(req_pready_s), 256'(8'h00));
        chk("t1_idle_paddr",  256'(cpl_paddr_s),  256'(32'h08));

        // All eight request at once after reset: served 0..7, once each
        do_reset();
        base  = order_q.size();
        wbase = wdata_q.size();
        for (int i = 0; i < N; i++) cnt0[i] = pready_cnt[i];
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i));
        run_idle(60, "t2_all_served");
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t2_order_%0d", k), 256'(q_at(base + k)), 256'(k));
            chk($sformatf("t2_cnt_%0d", k), 256'(pready_cnt[k] - cnt0[k]), 256'(1));
            chk($sformatf("t2_wdata_%0d", k),
                256'((wbase + k < wdata_q.size()) ? wdata_q[wbase + k] : 32'h0),
                256'(32'hA000_0000 | 32'(k)));
        end

        // Read by requester 5 with 4 completer wait states
        wait_cfg  = 4;
        rdata_cfg = 32'hDEAD_BEEF;
        set_req(5, 1'b0, 32'h14, 32'h0);
        exp_rd               = '0;
        exp_rd[5*DW +: DW]   = 32'hDEAD_BEEF;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("t3_prdata_c%0d", k), req_prdata_s, (k == 6) ? exp_rd : 256'(1'b0));
            chk($sformatf("t3_pready_c%0d", k), 256'(req_pready_s), 256'((k == 6) ? 8'h20 : 8'h00));
            if (k == 1) chk("t3_pwrite", 256'(cpl_pwrite_s), 256'(1'b0));
        end

        // Completer error for requester 2, then pointer must sit at 3
        wait_cfg  = 0;
        rdata_cfg = 32'h0;
        err_cfg   = 1'b1;
        set_req(2, 1'b1, 32'h20, 32'h55);
        cyc();
        chk("t4_setup_pslverr", 256'(req_pslverr_s), 256'(8'h00));
        cyc();
        chk("t4_pslverr", 256'(req_pslverr_s), 256'(8'h04));
        chk("t4_pready",  256'(req_pready_s),  256'(8'h04));
        cyc();
        chk("t4_after_pslverr", 256'(req_pslverr_s), 256'(8'h00));
        err_cfg = 1'b0;
        base    = order_q.size();
        set_req(1, 1'b1, 32'h04, 32'h11);
        set_req(2, 1'b1, 32'h08, 32'h22);
        set_req(3, 1'b1, 32'h0C, 32'h33);
        run_idle(30, "t4_rr_served");
        chk("t4_rr_first",  256'(q_at(base)),     256'(3));
        chk("t4_rr_wrap",   256'(q_at(base + 1)), 256'(1));
        chk("t4_rr_third",  256'(q_at(base + 2)), 256'(2));

        // Reset during ACCESS of requester 6
        wait_cfg = 1000;
        set_req(6, 1'b1, 32'h60, 32'h66);
        cyc();
        cyc();
        chk("t5_access_penable", 256'(cpl_penable_s), 256'(1'b1));
        chk("t5_access_grant",   256'(grant_idx_s),   256'(3'd6));
        #2;
        rst_s            = 1'b1;
        req_psel_s[6]    = 1'b0;
        req_penable_s[6] = 1'b0;
        #1;
        chk("t5_rst_psel",    256'(cpl_psel_s),    256'(1'b0));
        chk("t5_rst_penable", 256'(cpl_penable_s), 256'(1'b0));
        chk("t5_rst_grant",   256'(grant_idx_s),   256'(3'd0));
        chk("t5_rst_paddr",   256'(cpl_paddr_s),   256'(32'h0));
        chk("t5_rst_pwdata",  256'(cpl_pwdata_s),  256'(32'h0));
        chk("t5_rst_pready",  256'(req_pready_s),  256'(8'h00));
        chk("t5_rst_pslverr", 256'(req_pslverr_s), 256'(8'h00));
        wait_cfg = 0;
        set_req(1, 1'b1, 32'h100, 32'h1);
        set_req(5, 1'b1, 32'h500, 32'h5);
        base = order_q.size();
        @(negedge clk_s);
        rst_s = 1'b0;
        cyc();
        chk("t5_first_grant", 256'(grant_idx_s), 256'(3'd1));
        chk("t5_first_paddr", 256'(cpl_paddr_s), 256'(32'h100));
        run_idle(30, "t5_served");
        chk("t5_order_0", 256'(q_at(base)),     256'(1));
        chk("t5_order_1", 256'(q_at(base + 1)), 256'(5));

`ifdef APB_UART_ARB_WATCHDOG_EN
        // Silent completer: watchdog answers after 16 stalled ACCESS cycles
        wait_cfg  = 1000;
        rdata_cfg = 32'h1234_5678;
        set_req(4, 1'b0, 32'h40, 32'h0);
        cyc();
        for (int a = 1; a <= 16; a++) begin
            cyc();
            chk($sformatf("t6_wait_%0d", a), 256'(req_pready_s), 256'(8'h00));
        end
        cyc();
        chk("t6_wd_pready",  256'(req_pready_s),  256'(8'h10));
        chk("t6_wd_pslverr", 256'(req_pslverr_s), 256'(8'h10));
        chk("t6_wd_prdata",  req_prdata_s,        256'(1'b0));
        cyc();
        chk("t6_wd_idle_psel", 256'(cpl_psel_s), 256'(1'b0));
        wait_cfg = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
